// File: rtl/xor_nway_acc_pipe.sv
// xor_nway_acc_pipe: two-stage pipelined N-operand XOR with valid/ready
// handshake. Stage 1 folds the operands of one beat; stage 2 either forwards
// that word (pass mode) or accumulates it across a frame ending at in_last.
module xor_nway_acc_pipe #(
  parameter int WIDTH  = 128,
  parameter int NUM_IN = 3,
  parameter int BEAT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic                      in_last,
  input  logic                      in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_parity,
  output logic [BEAT_W-1:0]         out_beats,
  output logic                      out_sat
);

  localparam logic [BEAT_W-1:0] CNT_ONE = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] CNT_MAX = {BEAT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } frame_state_t;

  frame_state_t state_reg, state_next;
  logic         frame_mode_reg, frame_mode_next;
  logic         mode_eff;
  logic         accept;

  // Stage 1 registers
  logic [WIDTH-1:0] s1_data_reg;
  logic             s1_valid_reg;
  logic             s1_last_reg;
  logic             s1_take;

  // Stage 2 accumulator and output registers
  logic [WIDTH-1:0]  acc_reg, acc_next;
  logic [BEAT_W-1:0] cnt_reg, cnt_next;
  logic              sat_reg, sat_next;
  logic              first_reg;
  logic [WIDTH-1:0]  out_data_reg;
  logic              out_parity_reg;
  logic [BEAT_W-1:0] out_beats_reg;
  logic              out_sat_reg;
  logic              out_valid_reg;

  // XOR reduction tree built as a chain of partial folds over the operands
  logic [WIDTH-1:0] part [NUM_IN];

  assign part[0] = in_data[0 +: WIDTH];

  generate
    for (genvar gi = 1; gi < NUM_IN; gi++) begin : g_fold
      assign part[gi] = part[gi-1] ^ in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Stage 1 may only release a last beat when the output slot is free or
  // being drained; non-last beats always fold straight into the accumulator.
  assign s1_take  = s1_valid_reg && (!s1_last_reg || !out_valid_reg || out_ready);
  assign in_ready = !s1_valid_reg || s1_take;
  assign accept   = in_valid && in_ready;
  assign mode_eff = (state_reg == OPEN) ? frame_mode_reg : in_mode;

  // Frame state register: tracks whether an accumulate frame is open
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      frame_mode_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_mode_reg <= frame_mode_next;
    end
  end

  // Frame next-state: open on a non-last accumulate beat, close on in_last
  always_comb begin
    state_next      = state_reg;
    frame_mode_next = frame_mode_reg;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (mode_eff && !in_last) begin
            state_next      = OPEN;
            frame_mode_next = 1'b1;
          end
        end
        OPEN: begin
          if (in_last) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Stage 1: register the folded beat and whether it terminates a result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_reg  <= '0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
    end else begin
      if (accept) begin
        s1_data_reg  <= part[NUM_IN-1];
        s1_valid_reg <= 1'b1;
        s1_last_reg  <= !mode_eff || in_last;
      end else if (s1_take) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  // Stage 2 combinational fold: restart on the first beat of a frame
  always_comb begin
    acc_next = (first_reg ? '0 : acc_reg) ^ s1_data_reg;
    cnt_next = CNT_ONE;
    sat_next = 1'b0;
    if (!first_reg) begin
      cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_ONE;
      sat_next = sat_reg || (cnt_reg == CNT_MAX);
    end
  end

  // Stage 2 registers: fold non-last beats, publish the result on a last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      sat_reg        <= 1'b0;
      first_reg      <= 1'b1;
      out_data_reg   <= '0;
      out_parity_reg <= 1'b0;
      out_beats_reg  <= '0;
      out_sat_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      if (s1_take && !s1_last_reg) begin
        acc_reg   <= acc_next;
        cnt_reg   <= cnt_next;
        sat_reg   <= sat_next;
        first_reg <= 1'b0;
      end
      if (s1_take && s1_last_reg) begin
        out_data_reg   <= acc_next;
        out_parity_reg <= ^acc_next;
        out_beats_reg  <= cnt_next;
        out_sat_reg    <= sat_next;
        out_valid_reg  <= 1'b1;
        first_reg      <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_parity = out_parity_reg;
  assign out_beats  = out_beats_reg;
  assign out_sat    = out_sat_reg;

endmodule

// File: tb/tb_xor_nway_acc_pipe.sv
// Directed bench for xor_nway_acc_pipe at WIDTH=8, NUM_IN=3, BEAT_W=2.
module tb_xor_nway_acc_pipe;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 3;
  localparam int BEAT_W = 2;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    in_last;
  logic                    in_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_parity;
  logic [BEAT_W-1:0]       out_beats;
  logic                    out_sat;

  int tests_run = 0;
  int tests_failed = 0;

  xor_nway_acc_pipe #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .BEAT_W(BEAT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_parity(out_parity),
    .out_beats (out_beats),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] exp_data;
    logic       exp_par;
  } pass_vec_t;

  pass_vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, got);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic mode, input logic last);
    in_valid = 1'b1;
    in_data  = {c, b, a};
    in_mode  = mode;
    in_last  = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] d, input logic par,
                              input logic [1:0] beats, input logic sat);
    check({tag, ".valid"},  {31'd0, out_valid},  32'd1);
    check({tag, ".data"},   {24'd0, out_data},   {24'd0, d});
    check({tag, ".parity"}, {31'd0, out_parity}, {31'd0, par});
    check({tag, ".beats"},  {30'd0, out_beats},  {30'd0, beats});
    check({tag, ".sat"},    {31'd0, out_sat},    {31'd0, sat});
  endtask

  initial begin
    vecs[0] = '{8'h0F, 8'hF0, 8'h3C, 8'hC3, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[2] = '{8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
    vecs[3] = '{8'hAA, 8'h55, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 8'h56, 8'h70, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_mode = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_data",  {24'd0, out_data},  32'd0);
    check("rst.out_beats", {30'd0, out_beats}, 32'd0);
    check("rst.out_sat",   {31'd0, out_sat},   32'd0);
    rst = 1'b0;
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Pass mode vectors, one beat each, with latency check
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, 1'b0);
      check($sformatf("pass%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      idle_in();
      check($sformatf("pass%0d.early", i), {31'd0, out_valid}, 32'd0);
      tick();
      check_result($sformatf("pass%0d", i), vecs[i].exp_data, vecs[i].exp_par, 2'd1, 1'b0);
    end
    tick();

    // Back-to-back pass beats at full rate
    drive(8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    drive(8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    check("thru.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    drive(8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
    check("thru.r0", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h01});
    tick();
    idle_in();
    check("thru.r1", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h02});
    tick();
    check("thru.r2", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h03});
    tick();

    // Accumulate frame of three beats
    drive(8'h01, 8'h02, 8'h04, 1'b1, 1'b0);
    tick();
    drive(8'h08, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    check("acc.quiet1", {31'd0, out_valid}, 32'd0);
    drive(8'h10, 8'h00, 8'h00, 1'b1, 1'b1);
    tick();
    idle_in();
    check("acc.quiet2", {31'd0, out_valid}, 32'd0);
    tick();
    check_result("acc", 8'h1F, 1'b1, 2'd3, 1'b0);
    tick();

    // Saturation: five beats against a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(8'h01, 8'h00, 8'h00, 1'b1, (i == 4));
      tick();
    end
    idle_in();
    tick();
    check_result("sat", 8'h01, 1'b1, 2'd3, 1'b1);
    drive(8'h04, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    idle_in();
    tick();
    check_result("sat.clear", 8'h04, 1'b1, 2'd1, 1'b0);
    tick();

    // Backpressure: results held, nothing lost, order kept
    out_ready = 1'b0;
    drive(8'h11, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    drive(8'h22, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    drive(8'h33, 8'h00, 8'h00, 1'b0, 1'b0);
    check("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp.hold0", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h11});
    tick();
    tick();
    check("bp.in_ready_still_low", {31'd0, in_ready}, 32'd0);
    check("bp.hold1", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h11});
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_release", {31'd0, in_ready}, 32'd1);
    tick();
    idle_in();
    check("bp.r1", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h22});
    tick();
    check("bp.r2", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h33});
    tick();
    check("bp.drained", {31'd0, out_valid}, 32'd0);

    // Mode latch: in_mode dropped mid-frame is ignored
    drive(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    drive(8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    check("ml.quiet1", {31'd0, out_valid}, 32'd0);
    drive(8'h04, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    idle_in();
    check("ml.quiet2", {31'd0, out_valid}, 32'd0);
    tick();
    check_result("ml", 8'h07, 1'b1, 2'd3, 1'b0);
    tick();
    check("ml.single", {31'd0, out_valid}, 32'd0);

    // Reset mid-frame discards the open frame
    drive(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    drive(8'h02, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    idle_in();
    rst = 1'b1;
    #1;
    check("mrst.async_valid", {31'd0, out_valid}, 32'd0);
    check("mrst.async_data",  {24'd0, out_data},  32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mrst.in_ready", {31'd0, in_ready}, 32'd1);
    drive(8'hAA, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    idle_in();
    check("mrst.quiet", {31'd0, out_valid}, 32'd0);
    tick();
    check_result("mrst", 8'hAA, 1'b0, 2'd1, 1'b0);
    tick();
    check("mrst.single", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
